// File: rtl/traffic_lamp_monitor.sv
`default_nettype none
// ============================================================================
// Module   : traffic_lamp_monitor
// Purpose  : Independent receive-side checker for the 12 intersection lamp
//            drives. Decodes the lamp pattern into a phase number, locks onto
//            the 12-phase sequence and checks one-hot legality, phase order
//            and per-phase dwell time. The first violation is latched as a
//            sticky fault; completed signal cycles are counted.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_lamp_monitor #(
    parameter int G13_CYCLES = 31,  // dwell of L1_G and L3_G, in samples
    parameter int G24_CYCLES = 21,  // dwell of L2_G and L4_G, in samples
    parameter int Y_CYCLES   = 6,   // dwell of every yellow phase
    parameter int R_CYCLES   = 6    // dwell of every red (all-clear) phase
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       l1_green,
    input  logic       l1_yellow,
    input  logic       l1_red,
    input  logic       l2_green,
    input  logic       l2_yellow,
    input  logic       l2_red,
    input  logic       l3_green,
    input  logic       l3_yellow,
    input  logic       l3_red,
    input  logic       l4_green,
    input  logic       l4_yellow,
    input  logic       l4_red,
    input  logic       clear_fault,
    output logic [3:0] phase,
    output logic       phase_valid,
    output logic [5:0] dwell,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [3:0] fault_phase,
    output logic [7:0] cycle_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [2:0] c_CODE_NONE      = 3'd0;
    localparam logic [2:0] c_CODE_ONEHOT    = 3'd1;
    localparam logic [2:0] c_CODE_SEQUENCE  = 3'd2;
    localparam logic [2:0] c_CODE_OVERSTAY  = 3'd3;
    localparam logic [2:0] c_CODE_UNDERSTAY = 3'd4;

    localparam logic [3:0] c_LAST_PHASE  = 4'd11;
    localparam logic [7:0] c_CYCLE_MAX   = 8'd255;

    // ------------------------------------------------------------------------
    // Registered state and next-state wires
    // ------------------------------------------------------------------------
    state_t     r_state,        w_state;
    logic [3:0] r_phase,        w_phase;
    logic       r_phase_valid,  w_phase_valid;
    logic [5:0] r_dwell,        w_dwell;
    logic       r_fault,        w_fault;
    logic [2:0] r_fault_code,   w_fault_code;
    logic [3:0] r_fault_phase,  w_fault_phase;
    logic [7:0] r_cycle_count,  w_cycle_count;
    logic       r_first_phase,  w_first_phase;

    // ------------------------------------------------------------------------
    // Lamp decode
    // ------------------------------------------------------------------------
    // Bit index equals phase number: 0=L1_G, 1=L1_Y, 2=L1_R, 3=L2_G ... 11=L4_R.
    logic [11:0] w_lamps;
    logic        w_onehot;
    logic [3:0]  w_decoded;
    logic [3:0]  w_next_legal;
    logic [5:0]  w_expected;
    logic        w_changed;
    logic        w_understay;

    assign w_lamps = {l4_red, l4_yellow, l4_green,
                      l3_red, l3_yellow, l3_green,
                      l2_red, l2_yellow, l2_green,
                      l1_red, l1_yellow, l1_green};

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_onehot = (w_lamps != 12'd0) &&
                      ((w_lamps & (w_lamps - 12'd1)) == 12'd0);

    // Encode the lamp vector to a phase number; only meaningful when one-hot.
    always_comb begin
        w_decoded = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (w_lamps[i]) begin
                w_decoded = 4'(i);
            end
        end
    end

    // Phase succession wraps from L4_R back to L1_G.
    assign w_next_legal = (r_phase == c_LAST_PHASE) ? 4'd0 : (r_phase + 4'd1);

    // Required dwell of the phase currently being tracked.
    always_comb begin
        case (r_phase)
            4'd0, 4'd6:               w_expected = 6'(G13_CYCLES);
            4'd3, 4'd9:               w_expected = 6'(G24_CYCLES);
            4'd1, 4'd4, 4'd7, 4'd10:  w_expected = 6'(Y_CYCLES);
            default:                  w_expected = 6'(R_CYCLES);
        endcase
    end

    assign w_changed = (w_decoded != r_phase);

    // The phase seen at lock time may have been entered part-way through, so
    // it is only required not to exceed its dwell; later phases must reach it.
    assign w_understay = r_first_phase ? (r_dwell > w_expected)
                                       : (r_dwell < w_expected);

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    // Evaluates one lamp sample against the tracked phase, in violation priority.
    always_comb begin
        w_state       = r_state;
        w_phase       = r_phase;
        w_phase_valid = r_phase_valid;
        w_dwell       = r_dwell;
        w_fault       = r_fault;
        w_fault_code  = r_fault_code;
        w_fault_phase = r_fault_phase;
        w_cycle_count = r_cycle_count;
        w_first_phase = r_first_phase;

        case (r_state)
            ST_SYNC: begin
                // Dark or mixed lamps at start-up are tolerated silently.
                if (w_onehot) begin
                    w_state       = ST_TRACK;
                    w_phase       = w_decoded;
                    w_dwell       = 6'd1;
                    w_phase_valid = 1'b1;
                    w_first_phase = 1'b1;
                end
            end

            ST_TRACK: begin
                if (!w_onehot) begin
                    w_fault_code = c_CODE_ONEHOT;
                end else if (w_changed && (w_decoded != w_next_legal)) begin
                    w_fault_code = c_CODE_SEQUENCE;
                end else if (w_changed && w_understay) begin
                    w_fault_code = c_CODE_UNDERSTAY;
                end else if (!w_changed && (r_dwell == w_expected)) begin
                    w_fault_code = c_CODE_OVERSTAY;
                end else if (w_changed) begin
                    w_phase       = w_decoded;
                    w_dwell       = 6'd1;
                    w_first_phase = 1'b0;
                    if ((w_decoded == 4'd0) && (r_cycle_count != c_CYCLE_MAX)) begin
                        w_cycle_count = r_cycle_count + 8'd1;
                    end
                end else begin
                    w_dwell = r_dwell + 6'd1;
                end

                // Any violation freezes phase and dwell at their pre-sample values.
                if (w_fault_code != c_CODE_NONE) begin
                    w_fault       = 1'b1;
                    w_fault_phase = r_phase;
                    w_phase_valid = 1'b0;
                    w_state       = ST_FAULT;
                end
            end

            ST_FAULT: begin
                // Lamp inputs are ignored until the interlock releases the fault.
                if (clear_fault) begin
                    w_state       = ST_SYNC;
                    w_fault       = 1'b0;
                    w_fault_code  = c_CODE_NONE;
                    w_fault_phase = 4'd0;
                    w_dwell       = 6'd0;
                end
            end

            default: begin
                w_state = ST_SYNC;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // Asynchronous reset returns to SYNC with every output cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_SYNC;
            r_phase       <= 4'd0;
            r_phase_valid <= 1'b0;
            r_dwell       <= 6'd0;
            r_fault       <= 1'b0;
            r_fault_code  <= c_CODE_NONE;
            r_fault_phase <= 4'd0;
            r_cycle_count <= 8'd0;
            r_first_phase <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_phase       <= w_phase;
            r_phase_valid <= w_phase_valid;
            r_dwell       <= w_dwell;
            r_fault       <= w_fault;
            r_fault_code  <= w_fault_code;
            r_fault_phase <= w_fault_phase;
            r_cycle_count <= w_cycle_count;
            r_first_phase <= w_first_phase;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign phase       = r_phase;
    assign phase_valid = r_phase_valid;
    assign dwell       = r_dwell;
    assign fault       = r_fault;
    assign fault_code  = r_fault_code;
    assign fault_phase = r_fault_phase;
    assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_traffic_lamp_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_lamp_monitor
// Purpose  : Directed scoreboard bench for traffic_lamp_monitor. Stimulus
//            queues the expected registered outputs for each sample edge; a
//            monitor pops and compares them after every rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_lamp_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_fault;
    logic [11:0] r_lamps;

    logic [3:0]  phase;
    logic        phase_valid;
    logic [5:0]  dwell;
    logic        fault;
    logic [2:0]  fault_code;
    logic [3:0]  fault_phase;
    logic [7:0]  cycle_count;

    traffic_lamp_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .l1_green    (r_lamps[0]),
        .l1_yellow   (r_lamps[1]),
        .l1_red      (r_lamps[2]),
        .l2_green    (r_lamps[3]),
        .l2_yellow   (r_lamps[4]),
        .l2_red      (r_lamps[5]),
        .l3_green    (r_lamps[6]),
        .l3_yellow   (r_lamps[7]),
        .l3_red      (r_lamps[8]),
        .l4_green    (r_lamps[9]),
        .l4_yellow   (r_lamps[10]),
        .l4_red      (r_lamps[11]),
        .clear_fault (clear_fault),
        .phase       (phase),
        .phase_valid (phase_valid),
        .dwell       (dwell),
        .fault       (fault),
        .fault_code  (fault_code),
        .fault_phase (fault_phase),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    idx;
        string name;
        int    ph;
        int    valid;
        int    dw;
        int    flt;
        int    code;
        int    fph;
        int    cc;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   drv_n = 0;
    int   mon_n = 0;

    function automatic logic [11:0] oh(input int p);
        logic [11:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    // Timing plan: L1_G/L3_G 31, L2_G/L4_G 21, yellows and reds 6.
    function automatic int dur(input int p);
        if (p == 0 || p == 6) return 31;
        if (p == 3 || p == 9) return 21;
        return 6;
    endfunction

    function automatic void compare(input exp_t e);
        n_vec++;
        if (int'(phase) != e.ph || int'(phase_valid) != e.valid ||
            int'(dwell) != e.dw || int'(fault) != e.flt ||
            int'(fault_code) != e.code || int'(fault_phase) != e.fph ||
            int'(cycle_count) != e.cc) begin
            n_bad++;
            $display("FAIL %s (sample %0d): got ph=%0d v=%0d dw=%0d f=%0d code=%0d fph=%0d cc=%0d, want ph=%0d v=%0d dw=%0d f=%0d code=%0d fph=%0d cc=%0d",
                     e.name, e.idx, phase, phase_valid, dwell, fault, fault_code,
                     fault_phase, cycle_count, e.ph, e.valid, e.dw, e.flt,
                     e.code, e.fph, e.cc);
        end
    endfunction

    // Set the inputs for the next rising edge.
    task automatic drive(input logic [11:0] lamps, input logic clr);
        r_lamps     = lamps;
        clear_fault = clr;
        drv_n++;
    endtask

    // Queue the outputs expected after the edge that samples the last drive.
    task automatic expect_o(input string nm, input int ph, input int v,
                            input int dw, input int f, input int code,
                            input int fph, input int cc);
        exp_t e;
        e.idx = drv_n; e.name = nm; e.ph = ph; e.valid = v; e.dw = dw;
        e.flt = f; e.code = code; e.fph = fph; e.cc = cc;
        q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Golden run of n samples in phase p with no fault pending.
    task automatic hold(input int p, input int n, input int cc);
        for (int k = 0; k < n; k++) begin
            drive(oh(p), 1'b0);
            expect_o($sformatf("track_p%0d", p), p, 1, k + 1, 0, 0, 0, cc);
            tick();
        end
    endtask

    // Monitor: compare every queued expectation against the edge it targets.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mon_n++;
            while (q.size() > 0 && q[0].idx <= mon_n) begin
                exp_t e;
                e = q.pop_front();
                compare(e);
            end
        end
    end

    initial begin
        exp_t d;
        reset       = 1'b1;
        clear_fault = 1'b0;
        r_lamps     = '0;

        // Reset state
        for (int k = 0; k < 2; k++) begin
            drive(12'd0, 1'b0);
            expect_o("reset", 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        reset = 1'b0;

        // Golden stream: lock at L1_R, two full wraps, into L1_G
        hold(2, 6, 0);
        for (int p = 3; p < 12; p++) hold(p, dur(p), 0);
        hold(0, 31, 1);
        hold(1, 6, 1);
        hold(2, 6, 1);
        for (int p = 3; p < 12; p++) hold(p, dur(p), 1);
        hold(0, 3, 2);

        // Two lamps lit together while in L1_G
        drive(oh(0) | oh(2), 1'b0);
        expect_o("not_onehot", 0, 0, 3, 1, 1, 0, 2);
        tick();
        drive(oh(0), 1'b0);
        expect_o("fault_hold_a", 0, 0, 3, 1, 1, 0, 2);
        tick();
        drive(oh(1), 1'b0);
        expect_o("fault_hold_b", 0, 0, 3, 1, 1, 0, 2);
        tick();
        drive(oh(1), 1'b1);
        expect_o("clear_1", 0, 0, 0, 0, 0, 0, 2);
        tick();

        // L1_R then a jump to L3_G
        hold(2, 6, 2);
        drive(oh(6), 1'b0);
        expect_o("bad_sequence", 2, 0, 6, 1, 2, 2, 2);
        tick();
        drive(12'd0, 1'b1);
        expect_o("clear_2", 2, 0, 0, 0, 0, 0, 2);
        tick();

        // L2_G held one sample too long
        hold(2, 6, 2);
        hold(3, 21, 2);
        drive(oh(3), 1'b0);
        expect_o("overstay", 3, 0, 21, 1, 3, 3, 2);
        tick();
        drive(oh(3), 1'b1);
        expect_o("clear_3", 3, 0, 0, 0, 0, 0, 2);
        tick();

        // L2_Y left after 5 samples
        hold(2, 6, 2);
        hold(3, 21, 2);
        hold(4, 5, 2);
        drive(oh(5), 1'b0);
        expect_o("understay", 4, 0, 5, 1, 4, 4, 2);
        tick();
        drive(oh(5), 1'b1);
        expect_o("clear_4", 4, 0, 0, 0, 0, 0, 2);
        tick();
        drive(12'd0, 1'b0);
        expect_o("sync_dark", 4, 0, 0, 0, 0, 0, 2);
        tick();
        drive(oh(5), 1'b0);
        expect_o("relock", 5, 1, 1, 0, 0, 0, 2);
        tick();
        drive(oh(5), 1'b1);
        expect_o("clear_no_effect", 5, 1, 2, 0, 0, 0, 2);
        tick();

        // Fresh reset, partial first phase, one wrap, then async reset in L3_G
        reset = 1'b1;
        drive(12'd0, 1'b0);
        expect_o("reset_2", 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        hold(11, 1, 0);
        hold(0, 31, 1);
        hold(1, 6, 1);
        hold(2, 6, 1);
        hold(3, 21, 1);
        hold(4, 6, 1);
        hold(5, 6, 1);
        hold(6, 5, 1);
        #2;
        reset = 1'b1;
        #1;
        d.idx = -1; d.name = "async_reset"; d.ph = 0; d.valid = 0; d.dw = 0;
        d.flt = 0; d.code = 0; d.fph = 0; d.cc = 0;
        compare(d);
        drive(oh(6), 1'b0);
        expect_o("reset_held", 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(12'd0, 1'b0);
            expect_o("dark_after_reset", 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        drive(oh(0), 1'b0);
        expect_o("lock_after_reset", 0, 1, 1, 0, 0, 0, 0);
        tick();

        tick();
        tick();
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s: expectation for sample %0d left unchecked, monitor reached %0d",
                     e.name, e.idx, mon_n);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
